// File: rtl/axil_led_pwm_ctrl_if.sv
// rtl/axil_led_pwm_ctrl_if.sv - AXI4-Lite bus bundle for the LED/PWM controller
interface axil_led_pwm_ctrl_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
  logic                          awvalid;
  logic                          awready;
  logic [31:0]                   wdata;
  logic [3:0]                    wstrb;
  logic                          wvalid;
  logic                          wready;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
  logic                          arvalid;
  logic                          arready;
  logic [31:0]                   rdata;
  logic [1:0]                    rresp;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_led_pwm_ctrl.sv
// rtl/axil_led_pwm_ctrl.sv - AXI4-Lite LED controller with prescaled counter display
// Optional PWM brightness (DUTY register at 0x10) is built when LED_PWM_EN is defined.
module axil_led_pwm_ctrl #(
  parameter int NUM_LEDS           = 8,
  parameter int CNT_WIDTH          = 32,
  parameter int PWM_WIDTH          = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axil_led_pwm_ctrl_if.slave    s_axi,
  input  logic                  cnt_disp,
  output logic [NUM_LEDS-1:0]   leds
);
  localparam logic [2:0] OFF_DATA  = 3'd0;
  localparam logic [2:0] OFF_CTRL  = 3'd1;
  localparam logic [2:0] OFF_PRE   = 3'd2;
  localparam logic [2:0] OFF_COUNT = 3'd3;
  localparam logic [2:0] OFF_DUTY  = 3'd4;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [NUM_LEDS-1:0]  data_reg;
  logic                 mode;
  logic                 cnt_en;
  logic [31:0]          prescale;
  logic [31:0]          pcnt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           bresp_q;
  logic [1:0]           rresp_q;
  logic [31:0]          rdata_q;
  logic                 sync1, sync2;
  logic [NUM_LEDS-1:0]  sel;
  logic [2:0]           wr_off, rd_off;
  logic                 wr_mapped, rd_mapped;
  logic                 wr_fire, cnt_clr, pre_wr;
  logic [31:0]          rd_word;
  logic                 addr_unused;

`ifdef LED_PWM_EN
  logic [PWM_WIDTH-1:0] duty;
  logic [PWM_WIDTH-1:0] pwm_cnt;
`endif

  // Address LSBs and any bits above the 32-byte window are not decoded.
  assign addr_unused = ^{s_axi.awaddr, s_axi.araddr, (PWM_WIDTH > 0), (C_S_AXI_ADDR_WIDTH >= 5)};

  assign wr_off = s_axi.awaddr[4:2];
  assign rd_off = s_axi.araddr[4:2];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (s_axi.awvalid && s_axi.wvalid) wr_next = W_ACK;
      W_ACK:   wr_next = W_RESP;
      W_RESP:  if (s_axi.bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (s_axi.arvalid) rd_next = R_ACK;
      R_ACK:   rd_next = R_DATA;
      R_DATA:  if (s_axi.rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  assign s_axi.awready = (wr_state == W_ACK);
  assign s_axi.wready  = (wr_state == W_ACK);
  assign s_axi.bvalid  = (wr_state == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = (rd_state == R_ACK);
  assign s_axi.rvalid  = (rd_state == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  // COUNT is read-only, so a write there is treated like an unmapped hole.
  always_comb begin
    wr_mapped = 1'b0;
    case (wr_off)
      OFF_DATA, OFF_CTRL, OFF_PRE: wr_mapped = 1'b1;
`ifdef LED_PWM_EN
      OFF_DUTY: wr_mapped = 1'b1;
`endif
      default: wr_mapped = 1'b0;
    endcase
  end

  always_comb begin
    rd_mapped = 1'b0;
    rd_word   = 32'd0;
    case (rd_off)
      OFF_DATA:  begin rd_mapped = 1'b1; rd_word = 32'(data_reg); end
      OFF_CTRL:  begin rd_mapped = 1'b1; rd_word = {30'd0, cnt_en, mode}; end
      OFF_PRE:   begin rd_mapped = 1'b1; rd_word = prescale; end
      OFF_COUNT: begin rd_mapped = 1'b1; rd_word = 32'(cnt); end
`ifdef LED_PWM_EN
      OFF_DUTY:  begin rd_mapped = 1'b1; rd_word = 32'(duty); end
`endif
      default:   begin rd_mapped = 1'b0; rd_word = 32'd0; end
    endcase
  end

  assign wr_fire = (wr_state == W_ACK);
  assign cnt_clr = wr_fire && (wr_off == OFF_CTRL) && s_axi.wstrb[0] && s_axi.wdata[2];
  assign pre_wr  = wr_fire && (wr_off == OFF_PRE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_reg <= '0;
      mode     <= 1'b0;
      cnt_en   <= 1'b1;
      prescale <= 32'd0;
      bresp_q  <= RESP_OKAY;
    end else if (wr_fire) begin
      bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      case (wr_off)
        OFF_DATA: begin
          for (int i = 0; i < NUM_LEDS; i++)
            if (s_axi.wstrb[i/8]) data_reg[i] <= s_axi.wdata[i];
        end
        OFF_CTRL: begin
          if (s_axi.wstrb[0]) begin
            mode   <= s_axi.wdata[0];
            cnt_en <= s_axi.wdata[1];
          end
        end
        OFF_PRE: begin
          for (int i = 0; i < 32; i++)
            if (s_axi.wstrb[i/8]) prescale[i] <= s_axi.wdata[i];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q <= 32'd0;
      rresp_q <= RESP_OKAY;
    end else if (rd_state == R_ACK) begin
      rdata_q <= rd_mapped ? rd_word : 32'd0;
      rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Clear wins over the tick; a PRESCALE write restarts the divider phase.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt  <= '0;
      pcnt <= 32'd0;
    end else if (cnt_clr) begin
      cnt  <= '0;
      pcnt <= 32'd0;
    end else begin
      if (cnt_en) begin
        if (pcnt == prescale) begin
          cnt  <= cnt + CNT_WIDTH'(1);
          pcnt <= 32'd0;
        end else begin
          pcnt <= pcnt + 32'd1;
        end
      end
      if (pre_wr) pcnt <= 32'd0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= cnt_disp;
      sync2 <= sync1;
    end
  end

  assign sel = (sync2 || mode) ? cnt[NUM_LEDS-1:0] : data_reg;

`ifdef LED_PWM_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      duty <= '1;
    end else if (wr_fire && (wr_off == OFF_DUTY)) begin
      for (int i = 0; i < PWM_WIDTH; i++)
        if (s_axi.wstrb[i/8]) duty[i] <= s_axi.wdata[i];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pwm_cnt <= '0;
      leds    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
      leds    <= ((duty == '1) || (pwm_cnt < duty)) ? sel : '0;
    end
  end
`else
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) leds <= '0;
    else          leds <= sel;
  end
`endif
endmodule

// File: tb/tb_axil_led_pwm_ctrl.sv
// tb/tb_axil_led_pwm_ctrl.sv - directed self-checking bench for axil_led_pwm_ctrl
module tb_axil_led_pwm_ctrl;
  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       cnt_disp = 1'b0;
  logic [7:0] leds;
  int errors = 0;
  int checks = 0;

  axil_led_pwm_ctrl_if #(.C_S_AXI_ADDR_WIDTH(5)) bus ();

  axil_led_pwm_ctrl #(
    .NUM_LEDS(8), .CNT_WIDTH(32), .PWM_WIDTH(8), .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axi(bus), .cnt_disp(cnt_disp), .leds(leds)
  );

  always #5 aclk = ~aclk;

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    do begin @(posedge aclk); #1; n++; end while (!bus.awready && n < 20);
    checks++;
    if (bus.awready !== 1'b1) begin errors++; $display("FAIL awready_timeout addr=%h", a); end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    resp = bus.bresp;
    checks++;
    if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_late got=%b want=1", bus.bvalid); end
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
    do begin @(posedge aclk); #1; n++; end while (!bus.arready && n < 20);
    checks++;
    if (bus.arready !== 1'b1) begin errors++; $display("FAIL arready_timeout addr=%h", a); end
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_late got=%b want=1", bus.rvalid); end
    d = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0 ||
        bus.bresp !== 2'b0 || bus.rresp !== 2'b0 || bus.rdata !== 32'd0 || leds !== 8'h00)
      begin errors++; $display("FAIL reset_outputs rdata=%h leds=%h want all 0", bus.rdata, leds); end
    aresetn = 1'b1;
    axi_read(5'h00, d, r);
    checks++; if (d !== 32'd0 || r !== 2'b00) begin errors++; $display("FAIL reset_data got=%h/%b want=0/0", d, r); end
    axi_read(5'h04, d, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_ctrl got=%h want=2", d); end
    axi_read(5'h08, d, r);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_prescale got=%h want=0", d); end
  endtask

  task automatic test_data_leds();
    logic [7:0] vals [3] = '{8'h4b, 8'h36, 8'h98};
    logic [31:0] d; logic [1:0] r;
    for (int i = 0; i < 3; i++) begin
      axi_write(5'h00, {24'd0, vals[i]}, 4'hF, r);
      checks++;
      if (r !== 2'b00 || leds !== vals[i])
        begin errors++; $display("FAIL data_leds[%0d] leds=%h resp=%b want=%h/00", i, leds, r, vals[i]); end
    end
    axi_read(5'h00, d, r);
    checks++; if (d !== 32'h98 || r !== 2'b00) begin errors++; $display("FAIL data_read got=%h/%b want=98/00", d, r); end
  endtask

  task automatic test_counter();
    logic [1:0] r;
    logic [7:0] exp_l [4] = '{8'd1, 8'd2, 8'd2, 8'd3};
    int at_cyc [4] = '{8, 9, 12, 13};
    int cyc;
    axi_write(5'h08, 32'd3, 4'hF, r);
    axi_write(5'h04, 32'h6, 4'hF, r);
    // Now one cycle past the clear; count = floor(k/4) after k cycles from clear.
    cnt_disp = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    checks++; if (leds !== 8'h98) begin errors++; $display("FAIL disp_early got=%h want=98", leds); end
    @(posedge aclk); #1;
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL disp_3cyc got=%h want=00", leds); end
    cyc = 4;
    for (int i = 0; i < 4; i++) begin
      while (cyc < at_cyc[i]) begin @(posedge aclk); #1; cyc++; end
      checks++;
      if (leds !== exp_l[i]) begin errors++; $display("FAIL count_tick[%0d] got=%h want=%h", i, leds, exp_l[i]); end
    end
    cnt_disp = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (leds !== 8'h03) begin errors++; $display("FAIL undisp_early got=%h want=03", leds); end
    @(posedge aclk); #1;
    checks++; if (leds !== 8'h98) begin errors++; $display("FAIL undisp_3cyc got=%h want=98", leds); end
  endtask

  task automatic test_mode_clr();
    logic [31:0] d; logic [1:0] r;
    axi_write(5'h04, 32'h5, 4'hF, r);
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL mode_leds got=%h want=00", leds); end
    axi_read(5'h0C, d, r);
    checks++; if (d !== 32'd0 || r !== 2'b00) begin errors++; $display("FAIL clr_count got=%h/%b want=0/00", d, r); end
    axi_read(5'h04, d, r);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ctrl_readback got=%h want=1", d); end
  endtask

  task automatic test_strobe_err();
    logic [31:0] d; logic [1:0] r;
    axi_write(5'h04, 32'h0, 4'hF, r);
    axi_write(5'h00, 32'hAABBCCDD, 4'h1, r);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL strb_resp got=%b want=00", r); end
    axi_read(5'h00, d, r);
    checks++; if (d !== 32'hDD) begin errors++; $display("FAIL strb_data got=%h want=dd", d); end
    checks++; if (leds !== 8'hDD) begin errors++; $display("FAIL strb_leds got=%h want=dd", leds); end
    axi_read(5'h1C, d, r);
    checks++; if (d !== 32'd0 || r !== 2'b10) begin errors++; $display("FAIL unmapped_read got=%h/%b want=0/10", d, r); end
    axi_write(5'h0C, 32'h1234, 4'hF, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL count_write_resp got=%b want=10", r); end
    axi_read(5'h0C, d, r);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL count_unchanged got=%h want=0", d); end
  endtask

  task automatic test_hold();
    int n = 0;
    bus.awaddr = 5'h00; bus.wdata = 32'h5A; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    do begin @(posedge aclk); #1; n++; end while (!bus.awready && n < 20);
    @(posedge aclk); #1;
    checks++; if (leds !== 8'hDD) begin errors++; $display("FAIL hold_leds_pre got=%h want=dd", leds); end
    bus.wdata = 32'h77;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      checks++;
      if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0 || bus.bresp !== 2'b00 || leds !== 8'h5A)
        begin errors++; $display("FAIL bhold[%0d] bvalid=%b awready=%b leds=%h want 1/0/5a", i, bus.bvalid, bus.awready, leds); end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_drop got=%b want=0", bus.bvalid); end
    n = 0;
    bus.araddr = 5'h00; bus.arvalid = 1'b1; bus.rready = 1'b0;
    do begin @(posedge aclk); #1; n++; end while (!bus.arready && n < 20);
    @(posedge aclk); #1;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      checks++;
      if (bus.rvalid !== 1'b1 || bus.arready !== 1'b0 || bus.rdata !== 32'h5A || bus.rresp !== 2'b00)
        begin errors++; $display("FAIL rhold[%0d] rvalid=%b arready=%b rdata=%h want 1/0/5a", i, bus.rvalid, bus.arready, bus.rdata); end
    end
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.rready = 1'b0;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_drop got=%b want=0", bus.rvalid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r;
    bus.awaddr = 5'h1C; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    bus.araddr = 5'h1C; bus.arvalid = 1'b1; bus.rready = 1'b0;
    repeat (3) @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0 ||
        bus.bresp !== 2'b0 || bus.rresp !== 2'b0 || bus.rdata !== 32'd0 || leds !== 8'h00)
      begin errors++; $display("FAIL mid_reset bvalid=%b rvalid=%b bresp=%b rresp=%b leds=%h want 0", bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, leds); end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checks++; if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_resp bvalid=%b rvalid=%b want 0/0", bus.bvalid, bus.rvalid); end
    axi_read(5'h00, d, r);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL post_reset_data got=%h want=0", d); end
  endtask

  task automatic test_duty();
    logic [31:0] d; logic [1:0] r;
`ifdef LED_PWM_EN
    int hi;
    axi_read(5'h10, d, r);
    checks++; if (d !== 32'hFF || r !== 2'b00) begin errors++; $display("FAIL duty_reset got=%h/%b want=ff/00", d, r); end
    axi_write(5'h04, 32'h0, 4'hF, r);
    axi_write(5'h00, 32'hFF, 4'hF, r);
    axi_write(5'h10, 32'h40, 4'hF, r);
    hi = 0;
    for (int i = 0; i < 256; i++) begin @(posedge aclk); #1; if (leds === 8'hFF) hi++; end
    checks++; if (hi !== 64) begin errors++; $display("FAIL pwm_40 high=%0d want=64", hi); end
    axi_write(5'h10, 32'hFF, 4'hF, r);
    hi = 0;
    for (int i = 0; i < 20; i++) begin @(posedge aclk); #1; if (leds === 8'hFF) hi++; end
    checks++; if (hi !== 20) begin errors++; $display("FAIL pwm_ff high=%0d want=20", hi); end
    axi_write(5'h10, 32'h00, 4'hF, r);
    hi = 0;
    for (int i = 0; i < 20; i++) begin @(posedge aclk); #1; if (leds !== 8'h00) hi++; end
    checks++; if (hi !== 0) begin errors++; $display("FAIL pwm_00 high=%0d want=0", hi); end
`else
    axi_read(5'h10, d, r);
    checks++; if (d !== 32'd0 || r !== 2'b10) begin errors++; $display("FAIL duty_unmapped_read got=%h/%b want=0/10", d, r); end
    axi_write(5'h10, 32'h40, 4'hF, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL duty_unmapped_write got=%b want=10", r); end
`endif
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    test_reset();
    test_data_leds();
    test_counter();
    test_mode_clr();
    test_strobe_err();
    test_hold();
    test_reset_mid();
    test_duty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
